lsu_dmem_master: RTL
====================

Name: lsu_dmem_master

Overview:
Load/store unit that initiates accesses to the word-organised data memory (byte write strobes, one-cycle registered read). It accepts byte-addressed load and store requests from the pipeline and generates the word-level memory strobes. It splits accesses that straddle a word boundary into two consecutive word accesses, then aligns and sign- or zero-extends load data. It sits between the execute stage and dmem.

Parameters:
ADDR_WIDTH, 11, width of the dmem word address; legal byte range is 0 .. 4*2^ADDR_WIDTH-1.

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both high
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (error)
req_signed  in  1  load sign-extends when 1
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  qualifies resp_valid; request was rejected
mem_writeb  out  4  dmem byte write strobes
mem_read  out  1  dmem read strobe
mem_addr  out  ADDR_WIDTH  dmem word address
mem_wdata  out  32  dmem write data
mem_rdata  in  32  dmem read data, valid the cycle after mem_read

Behaviour:
- Synchronous active-low reset, single clock domain. Reset is synchronous and active-low; clk is the only clock.
- States: IDLE, ISSUE0, ISSUE1, CAPTURE, RESP.
- On acceptance, latch we, size, signed, off = addr[1:0], w0 = addr[ADDR_WIDTH+1:2], w1 = w0+1 and wdata.
- Lane mask: m64 = ({1,3,15}[size]) << off. Data: d64 = wdata << 8*off. split = (m64[7:4] != 0).
- err = (size == 3) OR (addr >= 4*2^ADDR_WIDTH) OR (split AND w0 == 2^ADDR_WIDTH-1). Wrap-around is never performed.
- IDLE: accept. If err, go to RESP with resp_err pending and issue no memory strobes. Otherwise go to ISSUE0.
- ISSUE0: mem_addr = w0. A load drives mem_read = 1. A store drives mem_writeb = m64[3:0] and mem_wdata = d64[31:0]. Next state is ISSUE1 if split; otherwise CAPTURE for a load or RESP for a store.
- ISSUE1: mem_addr = w1. A load drives mem_read = 1 and latches lo <= mem_rdata (word w0). A store drives mem_writeb = m64[7:4] and mem_wdata = d64[63:32]. Next state is CAPTURE for a load or RESP for a store.
- CAPTURE: build q = split ? {mem_rdata, lo} : {32'b0, mem_rdata}, then s = q >> 8*off. resp_rdata <= s masked to size, sign-extended if signed, else zero-extended. Next state is RESP.
- RESP: resp_valid = 1 for exactly one cycle, with resp_err as latched. Next state is IDLE. There is no response backpressure; the pipeline stalls on req_ready.
- mem_read, mem_writeb, mem_addr and mem_wdata are 0 in every state other than the active ISSUE state. At most one strobe type is asserted per cycle.
- Latency from the accept cycle to resp_valid:
  - aligned load: 3 cycles
  - aligned store: 2 cycles
  - split load: 4 cycles
  - split store: 3 cycles
  - error: 1 cycle
- A new request can be accepted in the cycle after RESP at the earliest.
- resp_rdata and resp_err hold their values until the next RESP.
- Reset (values also held while rst_n is low):
  - state = IDLE
  - resp_valid = 0, resp_err = 0, resp_rdata = 0
  - all mem_* outputs = 0, lo = 0
  - req_ready = 1 on the first cycle after rst_n rises.
- Reset mid-operation aborts the access. A store word already written in ISSUE0 stays written; no further strobes are issued and no response is produced.

Test Plan:
Memory is preloaded with word 4 = 0x44332211 and word 5 = 0x88776655.
1. Load word, addr 0x10 -> one mem_read with mem_addr 4; resp_valid 3 cycles after accept; resp_rdata 0x44332211, resp_err 0.
2. Load byte signed, addr 0x17 -> resp_rdata 0xFFFFFF88. Load byte unsigned, addr 0x17 -> 0x00000088. Load half signed, addr 0x12 -> 0x00004433.
3. Load word, addr 0x12 -> mem_read on two consecutive cycles with mem_addr 4 then 5; resp_rdata 0x66554433; latency 4.
4. Store half, addr 0x13, wdata 0xBEEF:
   - first write: mem_addr 4, writeb 1000, wdata 0xEF000000
   - second write: mem_addr 5, writeb 0001, wdata 0x000000BE
   - read-back: load word 0x10 -> 0xEF332211; load word 0x14 -> 0x887766BE.
5. Error cases, each giving resp_err 1 one cycle after accept, resp_rdata 0 and no mem strobes:
   - load word at 0x1FFE (spills past word 2047)
   - size 3 at 0x0
   - load byte at 0x2000
6. Reset during a split store (rst_n low during ISSUE1 of store word 0x12, wdata 0xAABBCCDD):
   - word 4 reads 0xCCDD2211 and word 5 is unchanged at 0x88776655
   - no resp_valid is produced
   - req_ready = 1 on the first cycle after rst_n rises
   - a following aligned load completes normally.

Source files
------------

// File: rtl/lsu_dmem_master.sv
// Load/store unit driving a word-organised data memory with byte strobes.
// Word-straddling accesses are split into two word accesses; load data is aligned and extended.
module lsu_dmem_master #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [3:0]            mem_writeb,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, CAPTURE, RESP} state_t;

    state_t                  state_reg, state_next;
    logic                    we_reg;
    logic [1:0]              size_reg;
    logic                    signed_reg;
    logic [1:0]              off_reg;
    logic [ADDR_WIDTH-1:0]   w0_reg, w1_reg;
    logic [31:0]             wdata_reg;
    logic [31:0]             lo_reg;
    logic [31:0]             resp_rdata_reg;
    logic                    resp_err_reg;

    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            2'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Request-side error detection, evaluated on the incoming request
    logic [7:0] req_m64;
    logic       req_split, req_last_word, req_oob, req_err;

    assign req_m64       = {4'b0000, lane_mask(req_size)} << req_addr[1:0];
    assign req_split     = |req_m64[7:4];
    assign req_last_word = (req_addr[ADDR_WIDTH+1:2] == {ADDR_WIDTH{1'b1}});
    assign req_oob       = |req_addr[31:ADDR_WIDTH+2];
    assign req_err       = (req_size == 2'd3) || req_oob || (req_split && req_last_word);

    // Lane mask and shifted data for the latched access
    logic [7:0]  m64;
    logic [63:0] d64;
    logic        split;

    assign m64   = {4'b0000, lane_mask(size_reg)} << off_reg;
    assign d64   = {32'b0, wdata_reg} << {off_reg, 3'b000};
    assign split = |m64[7:4];

    logic [63:0] q;
    logic [31:0] s;
    logic [31:0] ext;

    assign q = split ? {mem_rdata, lo_reg} : {32'b0, mem_rdata};
    assign s = 32'(q >> {off_reg, 3'b000});

    always_comb begin
        ext = s;
        case (size_reg)
            2'd0:    ext = signed_reg ? {{24{s[7]}}, s[7:0]} : {24'b0, s[7:0]};
            2'd1:    ext = signed_reg ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
            default: ext = s;
        endcase
    end

    logic                  ready_next, resp_valid_next, mem_read_next;
    logic [3:0]            mem_writeb_next;
    logic [ADDR_WIDTH-1:0] mem_addr_next;
    logic [31:0]           mem_wdata_next;

    always_comb begin
        state_next      = state_reg;
        ready_next      = 1'b0;
        resp_valid_next = 1'b0;
        mem_read_next   = 1'b0;
        mem_writeb_next = 4'b0000;
        mem_addr_next   = '0;
        mem_wdata_next  = 32'b0;
        case (state_reg)
            IDLE: begin
                ready_next = 1'b1;
                if (req_valid)
                    state_next = req_err ? RESP : ISSUE0;
            end
            ISSUE0: begin
                mem_addr_next = w0_reg;
                if (we_reg) begin
                    mem_writeb_next = m64[3:0];
                    mem_wdata_next  = d64[31:0];
                end else begin
                    mem_read_next = 1'b1;
                end
                if (split)
                    state_next = ISSUE1;
                else
                    state_next = we_reg ? RESP : CAPTURE;
            end
            ISSUE1: begin
                mem_addr_next = w1_reg;
                if (we_reg) begin
                    mem_writeb_next = m64[7:4];
                    mem_wdata_next  = d64[63:32];
                end else begin
                    mem_read_next = 1'b1;
                end
                state_next = we_reg ? RESP : CAPTURE;
            end
            CAPTURE: state_next = RESP;
            RESP: begin
                resp_valid_next = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            size_reg       <= 2'd0;
            signed_reg     <= 1'b0;
            off_reg        <= 2'd0;
            w0_reg         <= '0;
            w1_reg         <= '0;
            wdata_reg      <= 32'b0;
            lo_reg         <= 32'b0;
            resp_rdata_reg <= 32'b0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req_valid) begin
                we_reg     <= req_we;
                size_reg   <= req_size;
                signed_reg <= req_signed;
                off_reg    <= req_addr[1:0];
                w0_reg     <= req_addr[ADDR_WIDTH+1:2];
                w1_reg     <= req_addr[ADDR_WIDTH+1:2] + 1'b1;
                wdata_reg  <= req_wdata;
            end
            if (state_reg == ISSUE1 && !we_reg)
                lo_reg <= mem_rdata;
            // Response registers only change on the edge that enters RESP
            if (state_next == RESP && state_reg != RESP) begin
                resp_err_reg   <= (state_reg == IDLE);
                resp_rdata_reg <= (state_reg == CAPTURE) ? ext : 32'b0;
            end
        end
    end

    // Outputs are forced quiet while reset is held so an interrupted access issues nothing more
    assign req_ready  = rst_n & ready_next;
    assign resp_valid = rst_n & resp_valid_next;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign mem_read   = rst_n & mem_read_next;
    assign mem_writeb = rst_n ? mem_writeb_next : 4'b0000;
    assign mem_addr   = rst_n ? mem_addr_next : '0;
    assign mem_wdata  = rst_n ? mem_wdata_next : 32'b0;

endmodule
